rx_cic_decim: RTL and testbench
===============================

// Module: rx_cic_decim
// PURPOSE
//  CIC decimator for the RX chain. Consumes the 24-bit I/Q stream from the RX frontend (one sample per clk while
//  run=1) and emits decimated, gain-normalised, saturated 24-bit I/Q with an output strobe. It feeds the
//  halfband/DSP-core stage. Rate and normalisation shift are programmed over the settings bus.
// PARAMETERS
//  BASE      0   settings-bus base address (BASE: rate, BASE+1: shift)
//  WIDTH     24  I/Q sample width in and out
//  N         4   CIC order (integrator/comb pairs)
//  RATE_W    8   rate field width; max decimation 2^RATE_W-1
// PORTS
//  clk         in   1      system clock
//  rst         in   1      asynchronous reset, active-low
//  set_stb     in   1      settings write strobe
//  set_addr    in   8      settings address
//  set_data    in   32     settings data
//  run         in   1      1 = input valid every clk; 0 = idle and flush
//  i_in        in   WIDTH  I sample from frontend
//  q_in        in   WIDTH  Q sample from frontend
//  i_out       out  WIDTH  decimated I, valid with strobe_out
//  q_out       out  WIDTH  decimated Q, valid with strobe_out
//  strobe_out  out  1      one-clk pulse per output sample
//  debug       out  32     {run, strobe_out, clip_i, clip_q, cnt[RATE_W-1:0], 20'd0} (upper/lower split as listed)
// BEHAVIOUR
//  - Reset (rst=0): all integrators, combs, counter, i_out, q_out, strobe_out = 0; rate=1, shift=0.
//  - Accumulator width ACC_W = WIDTH + N*RATE_W, two's complement, wrap-around arithmetic (no clipping inside the CIC).
//  - Rate R = set_data[RATE_W-1:0] at BASE; shift S = set_data[5:0] at BASE+1, S <= ACC_W-WIDTH, larger values clamp.
//  - Bypass: R<=1 -> i_out/q_out = registered i_in/q_in, strobe_out = run delayed 1 clk; CIC state held at 0.
//  - Integrators: while run=1, N cascaded registered accumulators update every clk.
//  - Decim counter cnt counts 0..R-1 on run=1, wraps; on cnt==R-1 the last integrator output is sampled into the comb chain.
//  - Combs: N registered stages (y = x - x_delayed) fire only on decim sample; one stage per clk, pipelined.
//  - Output: comb result >>> S, then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; clip_i/clip_q flag for that sample.
//  - Latency: strobe_out asserts N+2 clk after the clk in which cnt==R-1; registered outputs hold between strobes.
//  - DC gain = R^N; software picks S = ceil(N*log2 R) for unity-ish gain.
//  - run 1->0: synchronous flush of integrators, combs, cnt next clk; no strobe_out after flush, any in-flight output dropped.
//  - Write to BASE or BASE+1 while run=1: same flush as run falling; new value applies from next clk.
//  - Simultaneous settings write and cnt==R-1: flush wins, sample discarded.
//  - rst asserted mid-operation: immediate return to reset state, no partial strobe.
// CONFIGURATION
//  RX_CIC_ROUND_EN defined: add 2^(S-1) (S>0) before the shift (round half up) prior to saturation.
//  Not defined: plain arithmetic shift (truncate toward -inf). Latency identical either way.
// STRUCTURE
//  Package rx_cic_pkg: ACC_W function, REG_RATE=0 / REG_SHIFT=1 offsets, saturate() function.
//  Sub-module cic_stage (one integrator+comb pair, parameter ACC_W), instantiated N times per rail via generate.
//  Settings decode via existing setting_reg instances; `changed` outputs drive the flush.
// TESTING
//  1. rst=0 with run=1, random inputs -> all outputs 0, strobe_out=0 throughout reset.
//  2. R=4, S=8, i_in=1000, q_in=-1000 const -> strobe every 4 clk; after N*R+N+2 clk, i_out=1000, q_out=-1000.
//  3. R=1 -> i_out == i_in delayed 1 clk, strobe_out == run delayed 1 clk.
//  4. R=16, S=0, i_in=8388607 -> i_out=8388607 with clip_i=1; i_in=-8388608 -> -8388608.
//  5. Drop run for 3 clk mid-stream, reassert -> no strobe during gap; output transient identical to first start.
//  6. R=2,N=4, S=4, i_in=1 -> gain 16 gives i_out=1; i_in=1,S=5 -> 1 with RX_CIC_ROUND_EN, 0 without.

Source files
------------

// File: rtl/rx_cic_pkg.sv
`default_nettype none
// ============================================================================
// Package : rx_cic_pkg
// Shared offsets, accumulator sizing and saturation helper for rx_cic_decim.
// Rev     : 1.0
// ============================================================================
package rx_cic_pkg;

    localparam int REG_RATE  = 0;
    localparam int REG_SHIFT = 1;
    localparam int SAT_W     = 64;

    typedef struct packed {
        logic             clip;
        logic [SAT_W-1:0] value;
    } sat_t;

    function automatic int acc_w(input int width, input int n, input int rate_w);
        return width + n * rate_w;
    endfunction

    // Clamp a sign-extended value into a signed field of 'width' bits.
    function automatic sat_t saturate(input logic signed [SAT_W-1:0] x, input int width);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t                    res;
        hi = $signed((SAT_W'(1) << (width - 1)) - SAT_W'(1));
        lo = ~hi;
        res.clip  = (x > hi) || (x < lo);
        res.value = (x > hi) ? hi : ((x < lo) ? lo : x);
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_cic_decim_stage.sv
`default_nettype none
// ============================================================================
// Module : cic_stage
// One CIC integrator plus one comb section, both cleared by a synchronous flush.
// Rev    : 1.0
// ============================================================================
module cic_stage
    import rx_cic_pkg::*;
#(
    parameter int ACC_W = 56
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic signed [ACC_W-1:0] integ_in,
    output logic signed [ACC_W-1:0] integ_out,
    input  logic                    comb_en,
    input  logic signed [ACC_W-1:0] comb_in,
    output logic signed [ACC_W-1:0] comb_out
);

    logic signed [ACC_W-1:0] r_integ;
    logic signed [ACC_W-1:0] r_comb_dly;
    logic signed [ACC_W-1:0] r_comb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_integ    <= '0;
            r_comb_dly <= '0;
            r_comb     <= '0;
        end else if (clr) begin
            r_integ    <= '0;
            r_comb_dly <= '0;
            r_comb     <= '0;
        end else begin
            r_integ <= r_integ + integ_in;
            if (comb_en) begin
                r_comb_dly <= comb_in;
                r_comb     <= comb_in - r_comb_dly;
            end
        end
    end

    assign integ_out = r_integ;
    assign comb_out  = r_comb;

endmodule
`default_nettype wire

// File: rtl/setting_reg.sv
`default_nettype none
// ============================================================================
// Module : setting_reg
// Settings-bus register: latches data on an address hit, flags the write cycle.
// Rev    : 1.0
// ============================================================================
module setting_reg #(
    parameter int          MY_ADDR  = 0,
    parameter int          WIDTH    = 32,
    parameter logic [31:0] AT_RESET = 32'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe,
    input  logic [7:0]       addr,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] out,
    output logic             changed
);

    // Combinational so the owner can act in the same cycle as the write.
    assign changed = strobe && (addr == 8'(MY_ADDR));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= AT_RESET[WIDTH-1:0];
        end else if (changed) begin
            out <= data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rx_cic_decim.sv
`default_nettype none
// ============================================================================
// Module : rx_cic_decim
// N-stage CIC decimator for I/Q with programmable rate/shift and saturation.
// Build option: RX_CIC_ROUND_EN selects round-half-up before the output shift.
// Rev    : 1.0
// ============================================================================
module rx_cic_decim
    import rx_cic_pkg::*;
#(
    parameter int BASE   = 0,
    parameter int WIDTH  = 24,
    parameter int N      = 4,
    parameter int RATE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic             run,
    input  logic [WIDTH-1:0] i_in,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] i_out,
    output logic [WIDTH-1:0] q_out,
    output logic             strobe_out,
    output logic [31:0]      debug
);

    localparam int ACC_W     = acc_w(WIDTH, N, RATE_W);
    localparam int MAX_SHIFT = ACC_W - WIDTH;
    localparam int DBG_PAD   = 28 - RATE_W;

    logic [RATE_W-1:0] w_rate;
    logic [5:0]        w_shift_raw;
    logic [5:0]        w_shift;
    logic              w_chg_rate;
    logic              w_chg_shift;
    logic              w_bypass;
    logic              w_flush;
    logic              w_dec;
    logic              w_unused_bits;

    logic [RATE_W-1:0]       r_cnt;
    logic [N:0]              r_vld;
    logic signed [ACC_W-1:0] r_samp_i;
    logic signed [ACC_W-1:0] r_samp_q;
    logic                    r_clip_i;
    logic                    r_clip_q;

    logic signed [ACC_W-1:0] w_integ_i [0:N];
    logic signed [ACC_W-1:0] w_integ_q [0:N];
    logic signed [ACC_W-1:0] w_comb_i  [0:N];
    logic signed [ACC_W-1:0] w_comb_q  [0:N];

    logic signed [ACC_W-1:0] w_rnd;
    logic signed [ACC_W-1:0] w_pre_i;
    logic signed [ACC_W-1:0] w_pre_q;
    logic signed [ACC_W-1:0] w_sh_i;
    logic signed [ACC_W-1:0] w_sh_q;
    sat_t                    w_sat_i;
    sat_t                    w_sat_q;

    setting_reg #(
        .MY_ADDR  (BASE + REG_RATE),
        .WIDTH    (RATE_W),
        .AT_RESET (32'd1)
    ) u_set_rate (
        .clk     (clk),
        .rst     (rst),
        .strobe  (set_stb),
        .addr    (set_addr),
        .data    (set_data[RATE_W-1:0]),
        .out     (w_rate),
        .changed (w_chg_rate)
    );

    setting_reg #(
        .MY_ADDR  (BASE + REG_SHIFT),
        .WIDTH    (6),
        .AT_RESET (32'd0)
    ) u_set_shift (
        .clk     (clk),
        .rst     (rst),
        .strobe  (set_stb),
        .addr    (set_addr),
        .data    (set_data[5:0]),
        .out     (w_shift_raw),
        .changed (w_chg_shift)
    );

    assign w_unused_bits = ^set_data[31:RATE_W]
                         ^ (^w_sat_i.value[SAT_W-1:WIDTH])
                         ^ (^w_sat_q.value[SAT_W-1:WIDTH]);

    assign w_bypass = (w_rate <= RATE_W'(1));
    // CIC state is cleared whenever idle, reconfigured or bypassed.
    assign w_flush  = !run || w_chg_rate || w_chg_shift || w_bypass;
    assign w_dec    = !w_flush && (r_cnt == (w_rate - RATE_W'(1)));
    assign w_shift  = ({26'd0, w_shift_raw} > 32'(MAX_SHIFT)) ? 6'(MAX_SHIFT) : w_shift_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_flush || w_dec) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + RATE_W'(1);
        end
    end

    // r_vld[k] marks the comb input of stage k as holding a fresh decimated sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld    <= '0;
            r_samp_i <= '0;
            r_samp_q <= '0;
        end else if (w_flush) begin
            r_vld    <= '0;
            r_samp_i <= '0;
            r_samp_q <= '0;
        end else begin
            r_vld <= {r_vld[N-1:0], w_dec};
            if (w_dec) begin
                r_samp_i <= w_integ_i[N];
                r_samp_q <= w_integ_q[N];
            end
        end
    end

    assign w_integ_i[0] = {{(ACC_W-WIDTH){i_in[WIDTH-1]}}, i_in};
    assign w_integ_q[0] = {{(ACC_W-WIDTH){q_in[WIDTH-1]}}, q_in};
    assign w_comb_i[0]  = r_samp_i;
    assign w_comb_q[0]  = r_samp_q;

    generate
        for (genvar k = 0; k < N; k++) begin : g_stage
            cic_stage #(.ACC_W(ACC_W)) u_stage_i (
                .clk       (clk),
                .rst       (rst),
                .clr       (w_flush),
                .integ_in  (w_integ_i[k]),
                .integ_out (w_integ_i[k+1]),
                .comb_en   (r_vld[k]),
                .comb_in   (w_comb_i[k]),
                .comb_out  (w_comb_i[k+1])
            );
            cic_stage #(.ACC_W(ACC_W)) u_stage_q (
                .clk       (clk),
                .rst       (rst),
                .clr       (w_flush),
                .integ_in  (w_integ_q[k]),
                .integ_out (w_integ_q[k+1]),
                .comb_en   (r_vld[k]),
                .comb_in   (w_comb_q[k]),
                .comb_out  (w_comb_q[k+1])
            );
        end
    endgenerate

`ifdef RX_CIC_ROUND_EN
    assign w_rnd = (w_shift == 6'd0) ? '0 : (ACC_W'(1) << (w_shift - 6'd1));
`else
    assign w_rnd = '0;
`endif

    assign w_pre_i = w_comb_i[N] + w_rnd;
    assign w_pre_q = w_comb_q[N] + w_rnd;
    assign w_sh_i  = w_pre_i >>> w_shift;
    assign w_sh_q  = w_pre_q >>> w_shift;
    assign w_sat_i = saturate(SAT_W'(w_sh_i), WIDTH);
    assign w_sat_q = saturate(SAT_W'(w_sh_q), WIDTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_out      <= '0;
            q_out      <= '0;
            strobe_out <= 1'b0;
            r_clip_i   <= 1'b0;
            r_clip_q   <= 1'b0;
        end else if (w_bypass) begin
            strobe_out <= run;
            r_clip_i   <= 1'b0;
            r_clip_q   <= 1'b0;
            if (run) begin
                i_out <= i_in;
                q_out <= q_in;
            end
        end else if (w_flush) begin
            strobe_out <= 1'b0;
        end else begin
            strobe_out <= r_vld[N];
            if (r_vld[N]) begin
                i_out    <= w_sat_i.value[WIDTH-1:0];
                q_out    <= w_sat_q.value[WIDTH-1:0];
                r_clip_i <= w_sat_i.clip;
                r_clip_q <= w_sat_q.clip;
            end
        end
    end

    assign debug = {run, strobe_out, r_clip_i, r_clip_q, r_cnt, {DBG_PAD{1'b0}}};

endmodule
`default_nettype wire

// File: tb/tb_rx_cic_decim.sv
`default_nettype none
// ============================================================================
// Module : tb_rx_cic_decim
// Scoreboard bench for rx_cic_decim with hand-computed decimator outputs.
// Rev    : 1.0
// ============================================================================
module tb_rx_cic_decim;

    localparam int LAT = 4 + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic        run = 1'b0;
    logic [23:0] i_in = '0;
    logic [23:0] q_in = '0;
    logic [23:0] i_out;
    logic [23:0] q_out;
    logic        strobe_out;
    logic [31:0] debug;

    typedef struct {
        int i;
        int q;
        bit ci;
        bit cq;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   exp_i[6];
    int   exp_q[6];

    localparam int BYP_I[5] = '{5, -7, 8388607, -8388608, 123456};
    localparam int BYP_Q[5] = '{-1, 100, -8388608, 8388607, -42};

    // Transients for a constant input: 4th difference of x*C(jR+R-1,4), then shifted.
`ifdef RX_CIC_ROUND_EN
    localparam int T2I[6]  = '{0, 137, 742, 996, 1000, 1000};
    localparam int T2Q[6]  = '{0, -137, -742, -996, -1000, -1000};
    localparam int T6I4[6] = '{0, 0, 0, 1, 1, 1};
    localparam int T6Q4[6] = '{0, 0, 0, -1, -1, -1};
    localparam int T6I5[6] = '{0, 0, 0, 0, 1, 1};
    localparam int T6Q5[6] = '{0, 0, 0, 0, 0, 0};
`else
    localparam int T2I[6]  = '{0, 136, 742, 996, 1000, 1000};
    localparam int T2Q[6]  = '{0, -137, -743, -997, -1000, -1000};
    localparam int T6I4[6] = '{0, 0, 0, 0, 1, 1};
    localparam int T6Q4[6] = '{0, 0, -1, -1, -1, -1};
    localparam int T6I5[6] = '{0, 0, 0, 0, 0, 0};
    localparam int T6Q5[6] = '{0, 0, -1, -1, -1, -1};
`endif
    localparam int T4I[6]  = '{8388607, 8388607, 8388607, 0, 0, 0};
    localparam int T4Q[6]  = '{-8388608, -8388608, -8388608, 0, 0, 0};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    rx_cic_decim dut (
        .clk        (clk),
        .rst        (rst),
        .set_stb    (set_stb),
        .set_addr   (set_addr),
        .set_data   (set_data),
        .run        (run),
        .i_in       (i_in),
        .q_in       (q_in),
        .i_out      (i_out),
        .q_out      (q_out),
        .strobe_out (strobe_out),
        .debug      (debug)
    );

    always @(negedge clk) begin
        if (rst && strobe_out) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: cyc=%0d i_out=%0d q_out=%0d, required no strobe",
                         cyc, $signed(i_out), $signed(q_out));
            end else begin
                mon_e = sbq.pop_front();
                if ($signed(i_out) != mon_e.i || $signed(q_out) != mon_e.q ||
                    debug[29] != mon_e.ci || debug[28] != mon_e.cq || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL strobe_sample: got i=%0d q=%0d ci=%0b cq=%0b cyc=%0d, required i=%0d q=%0d ci=%0b cq=%0b cyc=%0d",
                             $signed(i_out), $signed(q_out), debug[29], debug[28], cyc,
                             mon_e.i, mon_e.q, mon_e.ci, mon_e.cq, mon_e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        @(negedge clk);
        set_stb  = 1'b0;
    endtask

    task automatic expect_at(input int i, input int q, input bit ci, input bit cq, input int c);
        exp_t e;
        e.i   = i;
        e.q   = q;
        e.ci  = ci;
        e.cq  = cq;
        e.cyc = c;
        sbq.push_back(e);
    endtask

    // Runs k cycles from a clean state; the first n decimated outputs are expected.
    task automatic cic_phase(input int r, input int k, input int n, input bit ci, input bit cq);
        int p;
        p   = cyc;
        run = 1'b1;
        for (int j = 0; j < n; j++) begin
            expect_at(exp_i[j], exp_q[j], ci, cq, p + r - 1 + LAT + j * r);
        end
        tick(k);
        run = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;

        // Reset held with live stimulus
        rst = 1'b0;
        run = 1'b1;
        for (int c = 0; c < 4; c++) begin
            i_in = 24'($urandom);
            q_in = 24'($urandom);
            @(negedge clk);
            check("reset_i_out", $signed({40'd0, i_out}), 0);
            check("reset_q_out", $signed({40'd0, q_out}), 0);
            check("reset_strobe", $signed({63'd0, strobe_out}), 0);
            check("reset_debug", $signed({32'd0, debug}), 64'sh8000_0000);
        end
        run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick(2);

        // Bypass at the reset rate of 1
        p   = cyc;
        run = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_in = 24'(BYP_I[k]);
            q_in = 24'(BYP_Q[k]);
            expect_at(BYP_I[k], BYP_Q[k], 1'b0, 1'b0, p + k + 1);
            @(negedge clk);
        end
        run = 1'b0;
        tick(4);
        check("bypass_drain", sbq.size(), 0);

        // R=4, S=8, DC input; then a 3-cycle gap and identical restart
        wr(8'd0, 32'd4);
        wr(8'd1, 32'd8);
        i_in  = 24'(1000);
        q_in  = 24'(-1000);
        exp_i = T2I;
        exp_q = T2Q;
        cic_phase(4, 30, 6, 1'b0, 1'b0);
        tick(3);
        check("gap_no_strobe", sbq.size(), 0);
        cic_phase(4, 30, 6, 1'b0, 1'b0);
        tick(12);
        check("restart_drain", sbq.size(), 0);

        // R=2 gain 16 with S=4 and S=5
        wr(8'd0, 32'd2);
        wr(8'd1, 32'd4);
        i_in  = 24'(1);
        q_in  = 24'(-1);
        exp_i = T6I4;
        exp_q = T6Q4;
        cic_phase(2, 17, 6, 1'b0, 1'b0);
        tick(12);
        check("s4_drain", sbq.size(), 0);
        wr(8'd1, 32'd5);
        exp_i = T6I5;
        exp_q = T6Q5;
        cic_phase(2, 17, 6, 1'b0, 1'b0);
        tick(12);
        check("s5_drain", sbq.size(), 0);

        // R=16, S=0 full-scale input saturates both rails
        wr(8'd0, 32'd16);
        wr(8'd1, 32'd0);
        i_in  = 24'(8388607);
        q_in  = 24'(-8388608);
        exp_i = T4I;
        exp_q = T4Q;
        cic_phase(16, 54, 3, 1'b1, 1'b1);
        tick(30);
        check("sat_drain", sbq.size(), 0);

        // Asynchronous reset in the middle of a CIC run
        wr(8'd0, 32'd4);
        i_in = 24'(1000);
        run  = 1'b1;
        tick(6);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_i_out", $signed({40'd0, i_out}), 0);
        check("midrst_strobe", $signed({63'd0, strobe_out}), 0);
        check("midrst_cnt", $signed({56'd0, debug[27:20]}), 0);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        p    = cyc;
        run  = 1'b1;
        i_in = 24'(77);
        q_in = 24'(-77);
        expect_at(77, -77, 1'b0, 1'b0, p + 1);
        @(negedge clk);
        run = 1'b0;
        tick(4);
        check("post_reset_bypass", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
